mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares one `mem_system` instance (unified cache plus four-bank memory) between the fetch stage (read-only I-port) and the memory stage (read/write D-port). It picks one pending request using round-robin, issues it to `mem_system` as a one-cycle `Rd`/`Wr` pulse, and holds address and data stable until `Done` or a timeout. It then routes the result back to the granted requester.

## Interface
- `TIMEOUT`, default 64: maximum cycles in WAIT before the request is aborted with an error.
- `clk`  in  1  system clock; all flops rise on `posedge clk`.
- `rst`  in  1  synchronous, active-high reset.
- `i_rd`  in  1  instruction read request; level, held until `i_done`.
- `i_addr`  in  16  instruction address.
- `i_data_out`  out  16  read data; valid only when `i_done`=1.
- `i_done`, `i_hit`, `i_err`  out  1 each  completion pulse; cache hit; error.
- `i_stall`  out  1  `i_rd & ~i_done`.
- `d_rd`, `d_wr`  in  1 each  data read / write request; level, held until `d_done`.
- `d_addr`, `d_data_in`  in  16 each  data address and write data.
- `d_data_out`  out  16  read data.
- `d_done`, `d_hit`, `d_err`, `d_stall`  out  1 each  same meaning as the I-side outputs; `d_stall` = `(d_rd|d_wr) & ~d_done`.
- `m_addr`, `m_data_in`  out  16 each  driven to `mem_system` `Addr` and `DataIn`.
- `m_rd`, `m_wr`  out  1 each  driven to `mem_system` `Rd` and `Wr`.
- `m_data_out`  in  16  from `mem_system` `DataOut`.
- `m_done`, `m_stall`, `m_hit`, `m_err`  in  1 each  from `mem_system` `Done`, `Stall`, `CacheHit`, `err`.

## Operation
- **States:** IDLE, ISSUE, WAIT. All state is registered.
- **IDLE:**
  - Pending is defined as I = `i_rd`; D = `d_rd|d_wr`.
  - If neither is pending, stay in IDLE.
  - If exactly one is pending, grant it.
  - If both are pending, grant the side not granted last. `last_gnt` resets to I, so D wins the first tie.
  - On a grant, latch `{addr, data_in, rd, wr, side}` and go to ISSUE.
  - If `m_stall`=1 in IDLE (`mem_system` not yet idle), no grant is made.
- **ISSUE** (exactly one cycle): drive `m_addr`/`m_data_in` from the latch and assert `m_rd` or `m_wr`, then go to WAIT.
- **WAIT:**
  - Keep driving the latched `m_addr`/`m_data_in`; `m_rd`=`m_wr`=0.
  - On `m_done`: assert the granted side's done for one cycle, route `m_data_out` to its data output and `m_hit` to its hit output, update `last_gnt`, and go to IDLE.
- **mem_system error:** if `m_err`=1 at any cycle in WAIT, set the granted side's err together with its done, and go to IDLE.
- **Timeout:** a counter clears in ISSUE and increments in WAIT. When it reaches `TIMEOUT-1` without `m_done`, pulse done and err on the granted side and go to IDLE.
- **Illegal request:** `d_rd&d_wr`=1 when the D-side is selected means no issue. Pulse `d_done` and `d_err` in the next cycle (IDLE→IDLE) and toggle `last_gnt`.
- **Ungranted side:** done, hit and err stay 0. Its data output is don't-care; drive `m_data_out` to both sides.
- **Requester changes:** request and address changes after grant are ignored; the latched values are used.
- **Reset:**
  - Any cycle with `rst`=1 forces IDLE, `last_gnt`=I, counter=0.
  - All outputs are 0 that cycle: `m_*`, `*_done`, `*_hit`, `*_err`, `*_data_out`, `*_stall`.
  - Reset mid-transaction abandons it; `mem_system` shares `rst` and resets in the same cycle.

## Timing
- **Hit latency:** request seen in IDLE at cycle 0 → `m_rd`/`m_wr` at cycle 1 → `m_done` and requester done at cycle 2.
- **Miss:** done arrives whenever `m_done` arrives (about 12–20 cycles).
- Requester done and data are combinational from `m_done`/`m_data_out` in WAIT. There is no extra register stage.
- **After done:** the requester must drop or replace its request in the cycle after done. The arbiter is back in IDLE in that cycle and samples it again, so a held request is treated as a new request.
- **Back-to-back throughput:** at most one transaction per 3 cycles on hits.
- The `m_rd`/`m_wr` pulse width is exactly 1 cycle, and never both at once.

## Structure
- **Shared package `mem_arb_pkg`:** state encodings (IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10), side encodings (SIDE_I=0, SIDE_D=1) and the `TIMEOUT` default.
- **Sub-module `mem_arb_pick`:** combinational round-robin pick with inputs `(req_i, req_d, last_gnt)` and outputs `(gnt_valid, gnt_side)`.
- State, latch and timeout counter are in the top level. Use the team's `register` primitive for state and the latch.

## Test plan
- **Single I hit:** `i_rd`=1, `i_addr`=0x0040 on a preloaded line → `m_rd` at cycle 1, `i_done`=`i_hit`=1 at cycle 2, `i_data_out`= stored word; `d_*` outputs stay 0.
- **Simultaneous requests after reset:**
  - `i_rd`=1 @0x0100 and `d_wr`=1 @0x0200 with `d_data_in`=0xBEEF in the same cycle → D is issued first.
  - I is issued in the IDLE after `d_done`.
  - A following D read of 0x0200 returns 0xBEEF.
- **Continuous contention:** both sides request for 10 transactions → grants strictly alternate D, I, D, I…
- **Dirty miss with address changes:** D write miss on a dirty line → `m_addr` stays stable during the whole WAIT even though `d_addr` changes after grant; `d_done` arrives once.
- **Errors:**
  - `d_rd`=`d_wr`=1 → `d_done`=`d_err`=1 one cycle later, with no `m_rd`/`m_wr`.
  - `m_done` forced low → `d_err` pulses after `TIMEOUT` cycles in WAIT.
- **Reset mid-WAIT** (during a miss): `rst` held for 1 cycle → all outputs 0 and state IDLE; the next `i_rd` completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port mem_system arbiter: FSM states,
// requester side encodings and the default WAIT timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10
  } state_t;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational round-robin pick between the fetch (I) and memory (D) requesters.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_side
);

  // On a tie the side that was not served last wins; otherwise the lone requester.
  always_comb begin
    gnt_valid = req_i | req_d;
    if (req_i && req_d) begin
      gnt_side = ~last_gnt;
    end else if (req_d) begin
      gnt_side = SIDE_D;
    end else begin
      gnt_side = SIDE_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_system between the read-only I-port and the read/write D-port,
// issuing one latched request at a time and routing the result to its owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rd,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data_out,
  output logic        i_done,
  output logic        i_hit,
  output logic        i_err,
  output logic        i_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data_in,
  output logic [15:0] d_data_out,
  output logic        d_done,
  output logic        d_hit,
  output logic        d_err,
  output logic        d_stall,
  output logic [15:0] m_addr,
  output logic [15:0] m_data_in,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [15:0] m_data_out,
  input  logic        m_done,
  input  logic        m_stall,
  input  logic        m_hit,
  input  logic        m_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t        state_q, state_d;
  logic [15:0]   lat_addr, lat_data;
  logic          lat_rd, lat_wr, lat_side;
  logic          last_gnt_q;
  logic          illegal_q;
  logic [CW-1:0] cnt_q;

  logic          gnt_valid, gnt_side;
  logic          load, illegal_set, fin, fin_err, drive_bus;
  logic          timeout_hit;

  mem_arb_pick u_pick (
    .req_i     (i_rd),
    .req_d     (d_rd | d_wr),
    .last_gnt  (last_gnt_q),
    .gnt_valid (gnt_valid),
    .gnt_side  (gnt_side)
  );

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // Next-state logic; a pending illegal-request pulse blocks any new grant.
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    illegal_set = 1'b0;
    fin         = 1'b0;
    fin_err     = 1'b0;
    drive_bus   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!illegal_q && gnt_valid && !m_stall) begin
          if (gnt_side == SIDE_D && d_rd && d_wr) begin
            illegal_set = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        drive_bus = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        drive_bus = 1'b1;
        fin       = m_done | m_err | timeout_hit;
        fin_err   = m_err | (timeout_hit & ~m_done);
        if (fin) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= SIDE_I;
      illegal_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_set;
      if (illegal_set) begin
        last_gnt_q <= ~last_gnt_q;
      end else if (fin) begin
        last_gnt_q <= lat_side;
      end
    end
  end

  // The request is captured at grant so later requester changes cannot leak onto the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr <= '0;
      lat_data <= '0;
      lat_rd   <= 1'b0;
      lat_wr   <= 1'b0;
      lat_side <= SIDE_I;
    end else if (load) begin
      lat_side <= gnt_side;
      if (gnt_side == SIDE_D) begin
        lat_addr <= d_addr;
        lat_data <= d_data_in;
        lat_rd   <= d_rd;
        lat_wr   <= d_wr;
      end else begin
        lat_addr <= i_addr;
        lat_data <= '0;
        lat_rd   <= 1'b1;
        lat_wr   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Everything is forced low while reset is asserted, even mid-transaction.
  always_comb begin
    m_addr     = '0;
    m_data_in  = '0;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    i_data_out = '0;
    d_data_out = '0;
    i_done     = 1'b0;
    i_hit      = 1'b0;
    i_err      = 1'b0;
    d_done     = 1'b0;
    d_hit      = 1'b0;
    d_err      = 1'b0;
    i_stall    = 1'b0;
    d_stall    = 1'b0;
    if (!rst) begin
      if (drive_bus) begin
        m_addr    = lat_addr;
        m_data_in = lat_data;
      end
      if (state_q == ISSUE) begin
        m_rd = lat_rd;
        m_wr = lat_wr;
      end
      i_data_out = m_data_out;
      d_data_out = m_data_out;
      if (fin && lat_side == SIDE_I) begin
        i_done = 1'b1;
        i_hit  = m_hit;
        i_err  = fin_err;
      end
      if (fin && lat_side == SIDE_D) begin
        d_done = 1'b1;
        d_hit  = m_hit;
        d_err  = fin_err;
      end
      if (state_q == IDLE && illegal_q) begin
        d_done = 1'b1;
        d_err  = 1'b1;
      end
      i_stall = i_rd & ~i_done;
      d_stall = (d_rd | d_wr) & ~d_done;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter; the bench plays mem_system by driving m_* directly.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd;
  logic [15:0] i_addr;
  logic [15:0] i_data_out;
  logic        i_done, i_hit, i_err, i_stall;
  logic        d_rd, d_wr;
  logic [15:0] d_addr, d_data_in;
  logic [15:0] d_data_out;
  logic        d_done, d_hit, d_err, d_stall;
  logic [15:0] m_addr, m_data_in;
  logic        m_rd, m_wr;
  logic [15:0] m_data_out;
  logic        m_done, m_stall, m_hit, m_err;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_rd       (i_rd),
    .i_addr     (i_addr),
    .i_data_out (i_data_out),
    .i_done     (i_done),
    .i_hit      (i_hit),
    .i_err      (i_err),
    .i_stall    (i_stall),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_addr     (d_addr),
    .d_data_in  (d_data_in),
    .d_data_out (d_data_out),
    .d_done     (d_done),
    .d_hit      (d_hit),
    .d_err      (d_err),
    .d_stall    (d_stall),
    .m_addr     (m_addr),
    .m_data_in  (m_data_in),
    .m_rd       (m_rd),
    .m_wr       (m_wr),
    .m_data_out (m_data_out),
    .m_done     (m_done),
    .m_stall    (m_stall),
    .m_hit      (m_hit),
    .m_err      (m_err)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; i_rd = 1'b0; i_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_data_in = '0;
    m_data_out = '0; m_done = 1'b0; m_stall = 1'b0; m_hit = 1'b0; m_err = 1'b0;

    // Reset: outputs forced low even with a request present
    next_cycle();
    i_rd = 1'b1; i_addr = 16'h0040; m_data_out = 16'h1111;
    #1;
    check_output("rst_i_stall", i_stall, 0);
    check_output("rst_i_data", i_data_out, 16'h0000);
    check_output("rst_m_rd", m_rd, 0);
    next_cycle();
    rst = 1'b0; i_rd = 1'b0; m_data_out = '0;

    // Single I hit
    i_rd = 1'b1; i_addr = 16'h0040;
    #1;
    check_output("hit_i_stall_c0", i_stall, 1);
    next_cycle();
    #1;
    check_output("hit_m_rd_c1", m_rd, 1);
    check_output("hit_m_wr_c1", m_wr, 0);
    check_output("hit_m_addr_c1", m_addr, 16'h0040);
    check_output("hit_i_done_c1", i_done, 0);
    next_cycle();
    m_done = 1'b1; m_hit = 1'b1; m_data_out = 16'h1234;
    #1;
    check_output("hit_i_done_c2", i_done, 1);
    check_output("hit_i_hit_c2", i_hit, 1);
    check_output("hit_i_data_c2", i_data_out, 16'h1234);
    check_output("hit_i_stall_c2", i_stall, 0);
    check_output("hit_d_done_c2", d_done, 0);
    check_output("hit_d_hit_c2", d_hit, 0);
    check_output("hit_m_rd_c2", m_rd, 0);
    next_cycle();
    i_rd = 1'b0; m_done = 1'b0; m_hit = 1'b0;
    #1;
    check_output("hit_i_done_after", i_done, 0);

    // Simultaneous requests right after reset: D first, then I, then D read-back
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    i_rd = 1'b1; i_addr = 16'h0100;
    d_wr = 1'b1; d_addr = 16'h0200; d_data_in = 16'hBEEF;
    #1;
    check_output("sim_d_stall", d_stall, 1);
    next_cycle();
    #1;
    check_output("sim_first_m_wr", m_wr, 1);
    check_output("sim_first_m_rd", m_rd, 0);
    check_output("sim_first_addr", m_addr, 16'h0200);
    check_output("sim_first_wdata", m_data_in, 16'hBEEF);
    next_cycle();
    m_done = 1'b1; m_hit = 1'b1;
    #1;
    check_output("sim_d_done", d_done, 1);
    check_output("sim_i_done_idle", i_done, 0);
    check_output("sim_i_stall", i_stall, 1);
    next_cycle();
    m_done = 1'b0; d_wr = 1'b0;
    next_cycle();
    #1;
    check_output("sim_second_m_rd", m_rd, 1);
    check_output("sim_second_addr", m_addr, 16'h0100);
    next_cycle();
    m_done = 1'b1; m_data_out = 16'h5555;
    #1;
    check_output("sim_i_done", i_done, 1);
    check_output("sim_i_data", i_data_out, 16'h5555);
    next_cycle();
    i_rd = 1'b0; m_done = 1'b0;
    d_rd = 1'b1; d_addr = 16'h0200;
    next_cycle();
    #1;
    check_output("rb_m_rd", m_rd, 1);
    check_output("rb_addr", m_addr, 16'h0200);
    next_cycle();
    m_done = 1'b1; m_data_out = 16'hBEEF;
    #1;
    check_output("rb_d_done", d_done, 1);
    check_output("rb_d_data", d_data_out, 16'hBEEF);
    next_cycle();
    d_rd = 1'b0; m_done = 1'b0; m_hit = 1'b0;

    // Continuous contention after reset: D, I, D, I ...
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    i_rd = 1'b1; i_addr = 16'h0A00;
    d_rd = 1'b1; d_addr = 16'h0D00;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      #1;
      check_output("rr_addr", m_addr, (k % 2 == 0) ? 16'h0D00 : 16'h0A00);
      next_cycle();
      m_done = 1'b1; m_hit = 1'b1;
      #1;
      check_output("rr_d_done", d_done, (k % 2 == 0) ? 1'b1 : 1'b0);
      check_output("rr_i_done", i_done, (k % 2 == 0) ? 1'b0 : 1'b1);
      next_cycle();
      m_done = 1'b0; m_hit = 1'b0;
    end
    i_rd = 1'b0; d_rd = 1'b0;

    // Dirty write miss with requester address changing after grant
    d_wr = 1'b1; d_addr = 16'h0300; d_data_in = 16'hCAFE;
    next_cycle();
    #1;
    check_output("miss_m_wr", m_wr, 1);
    check_output("miss_issue_addr", m_addr, 16'h0300);
    d_addr = 16'h0777; d_data_in = 16'h0000;
    next_cycle();
    for (int k = 0; k < 15; k++) begin
      #1;
      check_output("miss_wait_addr", m_addr, 16'h0300);
      check_output("miss_wait_wdata", m_data_in, 16'hCAFE);
      check_output("miss_wait_done", d_done, 0);
      check_output("miss_wait_m_wr", m_wr, 0);
      next_cycle();
    end
    m_done = 1'b1;
    #1;
    check_output("miss_d_done", d_done, 1);
    check_output("miss_done_addr", m_addr, 16'h0300);
    next_cycle();
    d_wr = 1'b0; m_done = 1'b0;
    #1;
    check_output("miss_done_once", d_done, 0);

    // Illegal simultaneous D read and write
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0010;
    #1;
    check_output("ill_d_done_c0", d_done, 0);
    next_cycle();
    #1;
    check_output("ill_d_done_c1", d_done, 1);
    check_output("ill_d_err_c1", d_err, 1);
    check_output("ill_m_rd_c1", m_rd, 0);
    check_output("ill_m_wr_c1", m_wr, 0);
    check_output("ill_m_addr_c1", m_addr, 16'h0000);
    next_cycle();
    d_rd = 1'b0; d_wr = 1'b0;
    #1;
    check_output("ill_d_done_c2", d_done, 0);
    check_output("ill_m_wr_c2", m_wr, 0);

    // Timeout: m_done never arrives
    d_rd = 1'b1; d_addr = 16'h0400;
    next_cycle();
    next_cycle();
    for (int k = 0; k < 63; k++) begin
      #1;
      check_output("to_early_done", d_done, 0);
      next_cycle();
    end
    #1;
    check_output("to_d_done", d_done, 1);
    check_output("to_d_err", d_err, 1);
    check_output("to_i_err", i_err, 0);
    next_cycle();
    d_rd = 1'b0;
    #1;
    check_output("to_d_err_after", d_err, 0);

    // mem_system error during WAIT
    i_rd = 1'b1; i_addr = 16'h0700;
    next_cycle();
    next_cycle();
    m_err = 1'b1;
    #1;
    check_output("merr_i_done", i_done, 1);
    check_output("merr_i_err", i_err, 1);
    check_output("merr_d_err", d_err, 0);
    next_cycle();
    i_rd = 1'b0; m_err = 1'b0;
    #1;
    check_output("merr_i_err_after", i_err, 0);

    // Reset in the middle of a miss, then a normal I read
    i_rd = 1'b1; i_addr = 16'h0500;
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    check_output("mid_wait_addr", m_addr, 16'h0500);
    rst = 1'b1; m_data_out = 16'hFFFF;
    #1;
    check_output("mid_rst_m_addr", m_addr, 16'h0000);
    check_output("mid_rst_i_stall", i_stall, 0);
    check_output("mid_rst_i_data", i_data_out, 16'h0000);
    next_cycle();
    rst = 1'b0; i_addr = 16'h0600;
    #1;
    check_output("post_rst_idle_addr", m_addr, 16'h0000);
    next_cycle();
    #1;
    check_output("post_rst_m_rd", m_rd, 1);
    check_output("post_rst_addr", m_addr, 16'h0600);
    next_cycle();
    m_done = 1'b1; m_hit = 1'b1; m_data_out = 16'h0606;
    #1;
    check_output("post_rst_i_done", i_done, 1);
    check_output("post_rst_i_data", i_data_out, 16'h0606);
    next_cycle();
    i_rd = 1'b0; m_done = 1'b0; m_hit = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
